// File: rtl/issue_sb_queue.sv
// issue_sb_queue: in-order ring scoreboard (allocate -> issue -> writeback -> commit).
// Define ISSUE_SB_PERF_EN to build the saturating allocation-stall counter.
module issue_sb_queue #(
  parameter int NR_ENTRIES = 8,
  parameter int NR_ISSUE = 2,
  parameter int NR_WB = 4,
  parameter int NR_COMMIT = 2,
  parameter int PAYLOAD_W = 64,
  parameter int DATA_W = 64,
  localparam int ID_W = $clog2(NR_ENTRIES)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic flush_unissued_i,
  input  logic [NR_ISSUE-1:0] alloc_valid_i,
  output logic [NR_ISSUE-1:0] alloc_ready_o,
  input  logic [NR_ISSUE*PAYLOAD_W-1:0] alloc_payload_i,
  output logic [NR_ISSUE-1:0] issue_valid_o,
  input  logic [NR_ISSUE-1:0] issue_ack_i,
  output logic [NR_ISSUE*PAYLOAD_W-1:0] issue_payload_o,
  output logic [NR_ISSUE*ID_W-1:0] issue_id_o,
  input  logic [NR_WB-1:0] wb_valid_i,
  input  logic [NR_WB*ID_W-1:0] wb_id_i,
  input  logic [NR_WB*DATA_W-1:0] wb_data_i,
  input  logic [NR_WB-1:0] wb_ex_i,
  output logic [NR_COMMIT-1:0] commit_valid_o,
  input  logic [NR_COMMIT-1:0] commit_ack_i,
  output logic [NR_COMMIT*PAYLOAD_W-1:0] commit_payload_o,
  output logic [NR_COMMIT*DATA_W-1:0] commit_data_o,
  output logic [NR_COMMIT-1:0] commit_ex_o,
  output logic full_o,
  output logic [ID_W:0] count_o,
  output logic [31:0] stall_cnt_o
);
  typedef enum logic [1:0] {FREE, ALLOC, ISSUED, DONE} state_t;
  state_t r_state [NR_ENTRIES];
  logic [PAYLOAD_W-1:0] r_payload [NR_ENTRIES];
  logic [DATA_W-1:0] r_data [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] r_ex;
  logic [ID_W-1:0] r_commit_ptr, r_issue_ptr, r_alloc_ptr;
  logic [NR_ISSUE-1:0] w_alloc_fire, w_issue_fire;
  logic [NR_COMMIT-1:0] w_commit_fire;
  logic [ID_W:0] w_count;
  logic w_live, w_iss_live, w_pre;
  assign w_live = !rst_i && !flush_i;
  assign w_iss_live = w_live && !flush_unissued_i;
  assign count_o = w_count;
  assign full_o = w_count == (ID_W+1)'(NR_ENTRIES);
  // Every handshake is a prefix: lane k only counts when all lower lanes do.
  always_comb begin
    w_count = '0;
    for (int e = 0; e < NR_ENTRIES; e++) w_count = w_count + (ID_W+1)'(r_state[e] != FREE);
    w_pre = 1'b1;
    for (int k = 0; k < NR_ISSUE; k++) begin
      alloc_ready_o[k] = w_iss_live && w_pre && (w_count < (ID_W+1)'(NR_ENTRIES - k));
      w_pre = w_pre && alloc_valid_i[k];
    end
    w_alloc_fire = alloc_valid_i & alloc_ready_o;
    w_pre = 1'b1;
    for (int k = 0; k < NR_ISSUE; k++) begin
      issue_valid_o[k] = w_iss_live && w_pre && r_state[r_issue_ptr + ID_W'(k)] == ALLOC;
      w_pre = issue_valid_o[k];
      issue_payload_o[k*PAYLOAD_W +: PAYLOAD_W] = issue_valid_o[k] ? r_payload[r_issue_ptr + ID_W'(k)] : '0;
      issue_id_o[k*ID_W +: ID_W] = issue_valid_o[k] ? r_issue_ptr + ID_W'(k) : '0;
    end
    w_pre = 1'b1;
    for (int k = 0; k < NR_ISSUE; k++) begin
      w_pre = w_pre && issue_ack_i[k] && issue_valid_o[k];
      w_issue_fire[k] = w_pre;
    end
    w_pre = 1'b1;
    for (int k = 0; k < NR_COMMIT; k++) begin
      commit_valid_o[k] = w_live && w_pre && r_state[r_commit_ptr + ID_W'(k)] == DONE;
      w_pre = commit_valid_o[k];
      commit_payload_o[k*PAYLOAD_W +: PAYLOAD_W] = commit_valid_o[k] ? r_payload[r_commit_ptr + ID_W'(k)] : '0;
      commit_data_o[k*DATA_W +: DATA_W] = commit_valid_o[k] ? r_data[r_commit_ptr + ID_W'(k)] : '0;
      commit_ex_o[k] = commit_valid_o[k] && r_ex[r_commit_ptr + ID_W'(k)];
    end
    w_pre = 1'b1;
    for (int k = 0; k < NR_COMMIT; k++) begin
      w_pre = w_pre && commit_ack_i[k] && commit_valid_o[k];
      w_commit_fire[k] = w_pre;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_commit_ptr <= '0;
      r_issue_ptr <= '0;
      r_alloc_ptr <= '0;
      r_ex <= '0;
      for (int e = 0; e < NR_ENTRIES; e++) begin
        r_state[e] <= FREE;
        r_payload[e] <= '0;
        r_data[e] <= '0;
      end
    end else if (flush_i) begin
      r_commit_ptr <= '0;
      r_issue_ptr <= '0;
      r_alloc_ptr <= '0;
      for (int e = 0; e < NR_ENTRIES; e++) r_state[e] <= FREE;
    end else begin
      // Descending port scan so the lowest matching port lands last and wins.
      for (int e = 0; e < NR_ENTRIES; e++)
        for (int p = NR_WB - 1; p >= 0; p--)
          if (wb_valid_i[p] && wb_id_i[p*ID_W +: ID_W] == ID_W'(e) && r_state[e] == ISSUED) begin
            r_state[e] <= DONE;
            r_data[e] <= wb_data_i[p*DATA_W +: DATA_W];
            r_ex[e] <= wb_ex_i[p];
          end
      for (int k = 0; k < NR_COMMIT; k++)
        if (w_commit_fire[k]) r_state[r_commit_ptr + ID_W'(k)] <= FREE;
      for (int k = 0; k < NR_ISSUE; k++) begin
        if (w_issue_fire[k]) r_state[r_issue_ptr + ID_W'(k)] <= ISSUED;
        if (w_alloc_fire[k]) begin
          r_state[r_alloc_ptr + ID_W'(k)] <= ALLOC;
          r_payload[r_alloc_ptr + ID_W'(k)] <= alloc_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
        end
      end
      r_commit_ptr <= r_commit_ptr + ID_W'($countones(w_commit_fire));
      r_issue_ptr <= r_issue_ptr + ID_W'($countones(w_issue_fire));
      if (flush_unissued_i) begin
        r_alloc_ptr <= r_issue_ptr;
        for (int e = 0; e < NR_ENTRIES; e++)
          if (r_state[e] == ALLOC) r_state[e] <= FREE;
      end else r_alloc_ptr <= r_alloc_ptr + ID_W'($countones(w_alloc_fire));
    end
  end
`ifdef ISSUE_SB_PERF_EN
  logic [31:0] r_stall;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_stall <= '0;
    else if (alloc_valid_i[0] && !alloc_ready_o[0] && r_stall != '1) r_stall <= r_stall + 32'd1;
  end
  assign stall_cnt_o = r_stall;
`else
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_issue_sb_queue.sv
// tb_issue_sb_queue: directed + random stimulus against a queue-based scoreboard model.
module tb_issue_sb_queue;
  localparam int N = 8, NI = 2, NW = 4, NC = 2, PW = 64, DW = 64, IW = 3;
  logic clk = 1'b0, rst, flush, flushu;
  logic [NI-1:0] av, ar, iv, ia;
  logic [NI*PW-1:0] apl, ipl;
  logic [NI*IW-1:0] iid;
  logic [NW-1:0] wv, wex;
  logic [NW*IW-1:0] wid;
  logic [NW*DW-1:0] wdat;
  logic [NC-1:0] cv, ca, cex;
  logic [NC*PW-1:0] cpl;
  logic [NC*DW-1:0] cdat;
  logic full;
  logic [IW:0] cnt;
  logic [31:0] stall;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  issue_sb_queue dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_unissued_i(flushu),
    .alloc_valid_i(av), .alloc_ready_o(ar), .alloc_payload_i(apl),
    .issue_valid_o(iv), .issue_ack_i(ia), .issue_payload_o(ipl), .issue_id_o(iid),
    .wb_valid_i(wv), .wb_id_i(wid), .wb_data_i(wdat), .wb_ex_i(wex),
    .commit_valid_o(cv), .commit_ack_i(ca), .commit_payload_o(cpl),
    .commit_data_o(cdat), .commit_ex_o(cex),
    .full_o(full), .count_o(cnt), .stall_cnt_o(stall)
  );

  // Model: occupied entries oldest-first; st 1=allocated 2=issued 3=done.
  typedef struct {int st; logic [PW-1:0] pl; logic [DW-1:0] dat; logic ex;} ent_t;
  ent_t q[$];
  int head = 0;
  longint m_stall = 0;
  logic [NI-1:0] e_ar, e_iv;
  logic [NC-1:0] e_cv;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_alloc();
    for (int i = 0; i < q.size(); i++) if (q[i].st == 1) return i;
    return q.size();
  endfunction

  function automatic logic [31:0] exp_stall();
`ifdef ISSUE_SB_PERF_EN
    return m_stall[31:0];
`else
    return 32'd0;
`endif
  endfunction

  task automatic clr();
    av = '0; apl = '0; ia = '0; wv = '0; wid = '0; wdat = '0; wex = '0;
    ca = '0; flush = 1'b0; flushu = 1'b0;
  endtask

  task automatic set_wb(int p, int id, logic [DW-1:0] d, logic x);
    wv[p] = 1'b1; wid[p*IW +: IW] = IW'(id); wdat[p*DW +: DW] = d; wex[p] = x;
  endtask

  task automatic look();
    int fi, n;
    bit pre;
    #3;
    n = q.size();
    fi = first_alloc();
    pre = 1;
    for (int k = 0; k < NI; k++) begin
      e_ar[k] = !flush && !flushu && pre && (N - n > k);
      pre = pre && av[k];
    end
    for (int k = 0; k < NI; k++) e_iv[k] = !flush && !flushu && (fi + k < n);
    pre = 1;
    for (int k = 0; k < NC; k++) begin
      e_cv[k] = 1'b0;
      if (pre && !flush && k < n) e_cv[k] = (q[k].st == 3);
      pre = e_cv[k];
    end
    chk("alloc_ready", 128'(ar), 128'(e_ar));
    chk("issue_valid", 128'(iv), 128'(e_iv));
    chk("commit_valid", 128'(cv), 128'(e_cv));
    chk("count", 128'(cnt), 128'(n));
    chk("full", 128'(full), 128'(n == N));
    chk("stall_cnt", 128'(stall), 128'(exp_stall()));
    for (int k = 0; k < NI; k++) if (e_iv[k]) begin
      chk("issue_id", 128'(iid[k*IW +: IW]), 128'((head + fi + k) % N));
      chk("issue_payload", 128'(ipl[k*PW +: PW]), 128'(q[fi+k].pl));
    end
    for (int k = 0; k < NC; k++) if (e_cv[k]) begin
      chk("commit_payload", 128'(cpl[k*PW +: PW]), 128'(q[k].pl));
      chk("commit_data", 128'(cdat[k*DW +: DW]), 128'(q[k].dat));
      chk("commit_ex", 128'(cex[k]), 128'(q[k].ex));
    end
  endtask

  task automatic model_edge();
    int fi, ncm;
    bit pre;
    ent_t e;
    fi = first_alloc();
    if (av[0] && !e_ar[0] && m_stall < 64'hFFFFFFFF) m_stall++;
    if (flush) begin
      q.delete();
      head = 0;
      return;
    end
    for (int i = 0; i < q.size(); i++) if (q[i].st == 2) begin
      for (int p = 0; p < NW; p++) if (wv[p] && int'(wid[p*IW +: IW]) == (head + i) % N) begin
        q[i].st = 3; q[i].dat = wdat[p*DW +: DW]; q[i].ex = wex[p];
        break;
      end
    end
    pre = 1;
    for (int k = 0; k < NI; k++) begin
      pre = pre && ia[k] && e_iv[k];
      if (pre) q[fi+k].st = 2;
    end
    pre = 1;
    ncm = 0;
    for (int k = 0; k < NC; k++) begin
      pre = pre && ca[k] && e_cv[k];
      if (pre) ncm++;
    end
    if (flushu) begin
      while (q.size() > 0 && q[q.size()-1].st == 1) void'(q.pop_back());
    end else begin
      for (int k = 0; k < NI; k++) if (av[k] && e_ar[k]) begin
        e.st = 1; e.pl = apl[k*PW +: PW]; e.dat = '0; e.ex = 1'b0;
        q.push_back(e);
      end
    end
    repeat (ncm) void'(q.pop_front());
    head = (head + ncm) % N;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    clr();
  endtask

  task automatic cyc();
    look();
    tick();
  endtask

  task automatic rnd();
    av = NI'($urandom_range(0, 3));
    apl = {$urandom, $urandom, $urandom, $urandom};
    ia = NI'($urandom);
    for (int p = 0; p < NW; p++) begin
      wv[p] = 1'($urandom);
      wid[p*IW +: IW] = IW'($urandom_range(0, N - 1));
      wdat[p*DW +: DW] = {$urandom, $urandom};
      wex[p] = 1'($urandom);
    end
    ca = NC'($urandom);
    flushu = ($urandom_range(0, 31) == 0);
    flush = ($urandom_range(0, 63) == 0);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ready"}, 128'(ar), 128'(0));
    chk({tag, "_iv"}, 128'(iv), 128'(0));
    chk({tag, "_cv"}, 128'(cv), 128'(0));
    chk({tag, "_count"}, 128'(cnt), 128'(0));
    chk({tag, "_full"}, 128'(full), 128'(0));
    chk({tag, "_stall"}, 128'(stall), 128'(0));
    chk({tag, "_cdata"}, 128'(cdat), 128'(0));
    chk({tag, "_ipayload"}, 128'(ipl), 128'(0));
  endtask

  initial begin
    logic [63:0] s0;
    rst = 1'b1;
    clr();
    av = 2'b11;
    #2;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
    // Two allocations show up as issue candidates on the next cycle.
    av = 2'b11; apl = {64'hA1, 64'hA0};
    cyc();
    look();
    chk("r021_issue_valid", 128'(iv), 128'(2'b11));
    chk("r021_issue_id", 128'(iid), 128'({3'd1, 3'd0}));
    tick();
    ia = 2'b11;
    cyc();
    // Out-of-order writeback holds commit until the oldest completes.
    set_wb(0, 1, 64'hD1, 1'b0);
    cyc();
    look();
    chk("r023_commit_blocked", 128'(cv), 128'(0));
    set_wb(0, 0, 64'hD0, 1'b1);
    tick();
    look();
    chk("r023_commit_valid", 128'(cv), 128'(2'b11));
    chk("r023_commit_ex0", 128'(cex[0]), 128'(1));
    ca = 2'b11;
    tick();
    // Two ports hit id 3 in the same cycle; port 0 must win.
    av = 2'b11; apl = {64'hB3, 64'hB2};
    cyc();
    ia = 2'b11;
    cyc();
    set_wb(0, 3, 64'h11, 1'b0);
    set_wb(2, 3, 64'h22, 1'b0);
    set_wb(1, 2, 64'h20, 1'b0);
    cyc();
    look();
    chk("r024_commit_valid", 128'(cv), 128'(2'b11));
    chk("r024_wb_priority", 128'(cdat[127:64]), 128'(64'h11));
    ca = 2'b11;
    tick();
    // Fill, then show a same-cycle commit does not free a slot for allocation.
    repeat (4) begin
      av = 2'b11; apl = {$urandom, $urandom, $urandom, $urandom};
      cyc();
    end
    av = 2'b11;
    look();
    chk("r022_full", 128'(full), 128'(1));
    chk("r022_ready_full", 128'(ar), 128'(0));
    tick();
    ia = 2'b11;
    cyc();
    set_wb(0, 4, 64'h44, 1'b0);
    cyc();
    ca = 2'b01; av = 2'b01; apl = 128'hC0;
    look();
    chk("r022_same_cycle_refused", 128'(ar), 128'(0));
    tick();
    av = 2'b01; apl = 128'hC0;
    look();
    chk("r022_next_cycle_accepted", 128'(ar[0]), 128'(1));
    chk("r022_count7", 128'(cnt), 128'(7));
    tick();
    s0 = m_stall[63:0];
    repeat (10) begin
      av = 2'b01;
      cyc();
    end
    look();
`ifdef ISSUE_SB_PERF_EN
    chk("r026_stall10", 128'(stall), 128'(s0 + 64'd10));
`else
    chk("r026_stall_off", 128'(stall), 128'(0));
`endif
    tick();
    flush = 1'b1; av = 2'b11;
    look();
    chk("flush_issue_valid", 128'(iv), 128'(0));
    chk("flush_commit_valid", 128'(cv), 128'(0));
    tick();
    look();
    chk("flush_count", 128'(cnt), 128'(0));
    tick();
    // Three issued plus two allocated, then drop only the unissued pair.
    av = 2'b11; apl = {64'hE1, 64'hE0};
    cyc();
    av = 2'b11; apl = {64'hE3, 64'hE2};
    cyc();
    av = 2'b01; apl = 128'hE4;
    cyc();
    ia = 2'b11;
    cyc();
    ia = 2'b01;
    cyc();
    flushu = 1'b1; av = 2'b11; ia = 2'b11;
    look();
    chk("r025_count5", 128'(cnt), 128'(5));
    chk("r025_issue_masked", 128'(iv), 128'(0));
    tick();
    look();
    chk("r025_count3", 128'(cnt), 128'(3));
    tick();
    av = 2'b01; apl = 128'hF3;
    cyc();
    look();
    chk("r025_realloc_id", 128'(iid[IW-1:0]), 128'(3));
    ia = 2'b01;
    tick();
    for (int p = 0; p < 4; p++) set_wb(p, p, 64'h50 + 64'(p), 1'b0);
    cyc();
    look();
    chk("r025_issued_commit", 128'(cv), 128'(2'b11));
    ca = 2'b11;
    tick();
    ca = 2'b11;
    cyc();
    repeat (400) begin
      rnd();
      cyc();
    end
    // Asynchronous reset in the middle of a cycle with traffic pending.
    rnd();
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_ready", 128'(ar), 128'(0));
    chk("midrst_iv", 128'(iv), 128'(0));
    chk("midrst_cv", 128'(cv), 128'(0));
    chk("midrst_count", 128'(cnt), 128'(0));
    chk("midrst_stall", 128'(stall), 128'(0));
    q.delete();
    head = 0;
    m_stall = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
    repeat (60) begin
      rnd();
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
